// File: rtl/kc705_ethernet_tx_frame_arbiter_if.sv
// kc705_ethernet_tx_frame_arbiter_if
//   8-bit AXI-Stream byte channel used by the TX frame arbiter.
//   master : drives tdata/tvalid/tlast/tuser, samples tready
//   slave  : samples tdata/tvalid/tlast, drives tready
//   tuser is the error flag, qualified by tvalid & tlast; sources leave it unused.
interface kc705_ethernet_tx_frame_arbiter_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tuser;
  logic       tready;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/kc705_ethernet_tx_frame_arbiter.sv
// kc705_ethernet_tx_frame_arbiter
//   Shares one 8-bit AXI-Stream Ethernet TX path between two sources (s0
//   command/response, s1 ADC data). Whole frames are granted, an inter-frame
//   gap is inserted after every frame, over-long frames are truncated and
//   stalled frames are aborted; both close with tlast + tuser so the MAC
//   path never hangs.
// Ports:
//   axi_tclk, axi_tresetn : clock, async active-low reset
//   enable_arb            : allows new grants (a frame in flight always completes)
//   s0, s1                : source streams (slave modport)
//   m                     : stream to the TX MAC (master modport, tuser = error)
//   grant                 : one-hot owner, 00 when the path is free
//   abort_count           : saturating count of aborted/truncated frames
// Build option:
//   TX_ARB_FIXED_PRIORITY_EN : s0 always wins simultaneous requests and the
//                              round-robin pointer is removed.
module kc705_ethernet_tx_frame_arbiter #(
  parameter int MAX_FRAME_LEN = 1514,
  parameter int IFG_CYCLES    = 12,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic                                    axi_tclk,
  input  logic                                    axi_tresetn,
  input  logic                                    enable_arb,
  kc705_ethernet_tx_frame_arbiter_if.slave        s0,
  kc705_ethernet_tx_frame_arbiter_if.slave        s1,
  kc705_ethernet_tx_frame_arbiter_if.master       m,
  output logic [1:0]                              grant,
  output logic [7:0]                              abort_count
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_XFER  = 3'd1;
  localparam logic [2:0] S_ABORT = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam int SW = $clog2(STALL_TIMEOUT + 1);
  localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [15:0]   LAST_IDX   = 16'(MAX_FRAME_LEN - 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(IFG_CYCLES - 1);

  logic [2:0]      state;
  logic            owner;
  logic [15:0]     byte_cnt;
  logic [SW-1:0]   stall_cnt;
  logic [GW-1:0]   gap_cnt;

  logic [1:0][7:0] src_data;
  logic [1:0]      src_valid, src_last, src_ready;
  logic [7:0]      sel_data;
  logic            sel_valid, sel_last, at_limit, trunc, pick;
  logic [7:0]      abort_inc;

  assign src_data  = {s1.tdata,  s0.tdata};
  assign src_valid = {s1.tvalid, s0.tvalid};
  assign src_last  = {s1.tlast,  s0.tlast};
  assign s0.tready = src_ready[0];
  assign s1.tready = src_ready[1];

  assign sel_data  = src_data[owner];
  assign sel_valid = src_valid[owner];
  assign sel_last  = src_last[owner];
  // Beat at index MAX_FRAME_LEN-1 without source tlast is cut short here.
  assign at_limit  = (byte_cnt == LAST_IDX);
  assign trunc     = at_limit & ~sel_last;
  assign abort_inc = abort_count + {7'd0, (abort_count != 8'hFF)};

`ifdef TX_ARB_FIXED_PRIORITY_EN
  assign pick = ~src_valid[0];
`else
  logic ptr, frame_done;
  assign pick = (&src_valid) ? ptr : src_valid[1];
  // Any frame end (normal, truncate, abort) hands priority to the other source.
  assign frame_done = ((state == S_XFER) && sel_valid && m.tready && (sel_last || at_limit)) ||
                      ((state == S_ABORT) && m.tready);

  always_ff @(posedge axi_tclk or negedge axi_tresetn) begin
    if (!axi_tresetn)    ptr <= 1'b0;
    else if (frame_done) ptr <= ~owner;
  end
`endif

  always_comb begin
    m.tdata   = '0;
    m.tvalid  = 1'b0;
    m.tlast   = 1'b0;
    m.tuser   = 1'b0;
    src_ready = '0;
    case (state)
      S_XFER: begin
        m.tdata          = sel_data;
        m.tvalid         = sel_valid;
        m.tlast          = sel_last | at_limit;
        m.tuser          = trunc;
        src_ready[owner] = m.tready;
      end
      S_ABORT: begin
        m.tvalid = 1'b1;
        m.tlast  = 1'b1;
        m.tuser  = 1'b1;
      end
      S_FLUSH: src_ready[owner] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge axi_tclk or negedge axi_tresetn) begin
    if (!axi_tresetn) begin
      state       <= S_IDLE;
      grant       <= '0;
      owner       <= 1'b0;
      byte_cnt    <= '0;
      stall_cnt   <= '0;
      gap_cnt     <= '0;
      abort_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          byte_cnt  <= '0;
          stall_cnt <= '0;
          if (enable_arb && (|src_valid)) begin
            owner <= pick;
            grant <= pick ? 2'b10 : 2'b01;
            state <= S_XFER;
          end
        end
        S_XFER: begin
          if (sel_valid) begin
            stall_cnt <= '0;
            if (m.tready) begin
              if (sel_last) begin
                state   <= S_GAP;
                grant   <= '0;
                gap_cnt <= '0;
              end else if (at_limit) begin
                state       <= S_FLUSH;
                abort_count <= abort_inc;
              end else begin
                byte_cnt <= byte_cnt + 16'd1;
              end
            end
          end else if (stall_cnt == STALL_LAST) begin
            state <= S_ABORT;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        // Error beat is held until the MAC accepts it.
        S_ABORT: begin
          if (m.tready) begin
            state       <= S_FLUSH;
            abort_count <= abort_inc;
          end
        end
        // Drain the rest of the source's frame; nothing reaches the MAC.
        S_FLUSH: begin
          if (sel_valid && sel_last) begin
            state   <= S_GAP;
            grant   <= '0;
            gap_cnt <= '0;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) state <= S_IDLE;
          else                     gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_kc705_ethernet_tx_frame_arbiter.sv
module tb_kc705_ethernet_tx_frame_arbiter;
  localparam int MAXL = 1514;
  localparam int IFG  = 12;
  localparam int STO  = 1024;

  logic       axi_tclk = 1'b0;
  logic       axi_tresetn = 1'b0;
  logic       enable_arb = 1'b0;
  logic [1:0] grant;
  logic [7:0] abort_count;

  kc705_ethernet_tx_frame_arbiter_if s0_if ();
  kc705_ethernet_tx_frame_arbiter_if s1_if ();
  kc705_ethernet_tx_frame_arbiter_if m_if ();

  kc705_ethernet_tx_frame_arbiter #(
    .MAX_FRAME_LEN(MAXL), .IFG_CYCLES(IFG), .STALL_TIMEOUT(STO)
  ) dut (
    .axi_tclk(axi_tclk), .axi_tresetn(axi_tresetn), .enable_arb(enable_arb),
    .s0(s0_if), .s1(s1_if), .m(m_if),
    .grant(grant), .abort_count(abort_count)
  );

  always #5 axi_tclk = ~axi_tclk;

  int checks = 0, failures = 0, cyc = 0;
  // Source queues: -1 = one idle cycle, otherwise data | (last << 8)
  int q0[$], q1[$];
  int fr0[$], fr1[$];
  int st0 = -1, st1 = -1;
  bit hs0, hs1, rdy_rand = 1'b0;
  // Observed/expected beats: data | last<<8 | user<<9 | grant<<10
  int got[$], got_cyc[$], exp_q[$];
  int ptr_m = 0, exp_abort = 0, w;

  always @(posedge axi_tclk) cyc++;

  always @(negedge axi_tclk) begin
    hs0 = s0_if.tvalid & s0_if.tready;
    hs1 = s1_if.tvalid & s1_if.tready;
    if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
      got.push_back(int'({grant, m_if.tuser, m_if.tlast, m_if.tdata}));
      got_cyc.push_back(cyc);
    end
  end

  always @(posedge axi_tclk) begin : drv0
    int h;
    #1;
    if (q0.size() > 0 && (q0[0] < 0 || hs0)) void'(q0.pop_front());
    if (q0.size() > 0 && q0[0] >= 0) begin
      h = q0[0];
      s0_if.tvalid = 1'b1; s0_if.tdata = h[7:0]; s0_if.tlast = h[8];
    end else begin
      s0_if.tvalid = 1'b0; s0_if.tdata = 8'h00; s0_if.tlast = 1'b0;
    end
  end

  always @(posedge axi_tclk) begin : drv1
    int h;
    #1;
    if (q1.size() > 0 && (q1[0] < 0 || hs1)) void'(q1.pop_front());
    if (q1.size() > 0 && q1[0] >= 0) begin
      h = q1[0];
      s1_if.tvalid = 1'b1; s1_if.tdata = h[7:0]; s1_if.tlast = h[8];
    end else begin
      s1_if.tvalid = 1'b0; s1_if.tdata = 8'h00; s1_if.tlast = 1'b0;
    end
  end

  always @(posedge axi_tclk) begin
    #1;
    m_if.tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push_frame(input int src, input int len, input int stall_after);
    int fr[$];
    int b;
    for (int i = 0; i < len; i++) begin
      if (i == stall_after)
        for (int k = 0; k < STO + 6; k++) begin
          if (src == 0) q0.push_back(-1); else q1.push_back(-1);
        end
      b = int'($urandom_range(0, 255)) | ((i == len - 1) ? 256 : 0);
      if (src == 0) q0.push_back(b); else q1.push_back(b);
      fr.push_back(b);
    end
    if (src == 0) begin fr0 = fr; st0 = stall_after; end
    else          begin fr1 = fr; st1 = stall_after; end
  endtask

  // Frame-level model: what the MAC must see for one granted frame.
  task automatic expect_frame(input int src);
    int fr[$];
    int st, g;
    if (src == 0) begin fr = fr0; st = st0; end
    else          begin fr = fr1; st = st1; end
    g = (src == 0 ? 1 : 2) << 10;
    if (st >= 0 && st < fr.size()) begin
      for (int i = 0; i < st; i++) exp_q.push_back(fr[i] | g);
      exp_q.push_back((3 << 8) | g);
      exp_abort = (exp_abort < 255) ? exp_abort + 1 : 255;
    end else if (fr.size() > MAXL) begin
      for (int i = 0; i < MAXL; i++)
        exp_q.push_back((fr[i] & 255) | ((i == MAXL - 1) ? (3 << 8) : 0) | g);
      exp_abort = (exp_abort < 255) ? exp_abort + 1 : 255;
    end else begin
      for (int i = 0; i < fr.size(); i++) exp_q.push_back(fr[i] | g);
    end
    ptr_m = 1 - src;
  endtask

  function automatic int winner();
`ifdef TX_ARB_FIXED_PRIORITY_EN
    return 0;
`else
    return ptr_m;
`endif
  endfunction

  task automatic wait_got(input int n);
    int k = 0;
    while (got.size() < n && k < 20000) begin @(negedge axi_tclk); k++; end
  endtask

  task automatic run_check(input string tag);
    int k = 0;
    while ((got.size() < exp_q.size() || q0.size() > 0 || q1.size() > 0) && k < 20000) begin
      @(negedge axi_tclk); k++;
    end
    repeat (20) @(negedge axi_tclk);
    chk({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), got[i], exp_q[i]);
    chk({tag, "_abort_count"}, abort_count, exp_abort);
  endtask

  task automatic clr();
    got.delete(); got_cyc.delete(); exp_q.delete();
  endtask

  initial begin
    s0_if.tvalid = 1'b0; s0_if.tdata = 8'h00; s0_if.tlast = 1'b0; s0_if.tuser = 1'b0;
    s1_if.tvalid = 1'b0; s1_if.tdata = 8'h00; s1_if.tlast = 1'b0; s1_if.tuser = 1'b0;
    m_if.tready = 1'b1;
    repeat (3) @(negedge axi_tclk);
    chk("rst_grant", grant, 0);
    chk("rst_m_tvalid", m_if.tvalid, 0);
    chk("rst_m_tlast", m_if.tlast, 0);
    chk("rst_m_tuser", m_if.tuser, 0);
    chk("rst_m_tdata", m_if.tdata, 0);
    chk("rst_s0_tready", s0_if.tready, 0);
    chk("rst_s1_tready", s1_if.tready, 0);
    chk("rst_abort_count", abort_count, 0);
    axi_tresetn = 1'b1;
    enable_arb  = 1'b1;
    repeat (2) @(negedge axi_tclk);

    // Simultaneous 64-byte requests, then gap timing between them
    push_frame(0, 64, -1); push_frame(1, 64, -1);
    w = winner(); expect_frame(w); expect_frame(1 - w);
    run_check("simul");
    chk("simul_gap", (got_cyc.size() > 64) ? got_cyc[64] - got_cyc[63] : -1, IFG + 2);
    clr();

    // Lone s0 frame moves the pointer; the next tie shows the policy
    push_frame(0, 16, -1); expect_frame(0); run_check("solo"); clr();
    push_frame(0, 16, -1); push_frame(1, 16, -1);
    w = winner(); expect_frame(w); expect_frame(1 - w);
    run_check("tie2"); clr();

    // Backpressure on a 100-byte s1 frame
    rdy_rand = 1'b1;
    push_frame(1, 100, -1); expect_frame(1); run_check("bp"); clr();
    rdy_rand = 1'b0;
    repeat (2) @(negedge axi_tclk);

    // Truncation of a 1600-byte s0 frame
    push_frame(0, 1600, -1); expect_frame(0); run_check("trunc"); clr();

    // Stall abort: 10 bytes then a long idle stretch
    push_frame(1, 30, 10); expect_frame(1); run_check("stall");
    chk("stall_delay", (got_cyc.size() > 10) ? got_cyc[10] - got_cyc[9] : -1, STO + 1);
    clr();

    // enable_arb drops mid-frame: frame completes, no new grant
    push_frame(0, 40, -1); expect_frame(0);
    wait_got(20);
    enable_arb = 1'b0;
    push_frame(1, 8, -1); push_frame(0, 8, -1);
    wait_got(40);
    repeat (40) @(negedge axi_tclk);
    chk("dis_beats", got.size(), 40);
    chk("dis_grant", grant, 0);
    chk("dis_both_waiting", {s1_if.tvalid, s0_if.tvalid}, 3);
    enable_arb = 1'b1;
    w = winner(); expect_frame(w); expect_frame(1 - w);
    run_check("dis"); clr();

    // Async reset in the middle of a frame
    push_frame(0, 50, -1);
    wait_got(5);
    @(negedge axi_tclk);
    #2 axi_tresetn = 1'b0;
    #1;
    chk("arst_grant", grant, 0);
    chk("arst_m_tvalid", m_if.tvalid, 0);
    chk("arst_s0_tready", s0_if.tready, 0);
    chk("arst_abort_count", abort_count, 0);
    q0.delete(); q1.delete();
    repeat (3) @(negedge axi_tclk);
    clr();
    ptr_m = 0; exp_abort = 0;
    axi_tresetn = 1'b1;
    repeat (2) @(negedge axi_tclk);

    // Pointer is back at s0 after reset
    push_frame(1, 12, -1); push_frame(0, 12, -1);
    w = winner(); expect_frame(w); expect_frame(1 - w);
    run_check("post_rst"); clr();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/kc705_ethernet_tx_frame_arbiter.md
# kc705_ethernet_tx_frame_arbiter

Frame-level arbiter that shares the single 8-bit AXI-Stream Ethernet TX path between two byte-stream requesters: source 0 (command/response frames) and source 1 (ADC data frames). It grants whole frames and never interleaves bytes from different frames. It enforces an inter-frame gap and a maximum frame length. A stalled or runaway source is aborted with an error-flagged `tlast` so the MAC path cannot hang.

## Interface
Parameters:
- `MAX_FRAME_LEN`, 1514: maximum bytes per frame, 16-bit counter.
- `IFG_CYCLES`, 12: idle cycles after every frame.
- `STALL_TIMEOUT`, 1024: consecutive cycles of `tvalid` low mid-frame before abort.

Ports (clock and reset first):
- `axi_tclk` in 1: single clock. Reset is asynchronous, active-low.
- `axi_tresetn` in 1: asynchronous active-low reset.
- `enable_arb` in 1: when high, new grants are allowed.
- `s0_tdata` in 8, `s0_tvalid` in 1, `s0_tlast` in 1, `s0_tready` out 1: source 0 stream.
- `s1_tdata` in 8, `s1_tvalid` in 1, `s1_tlast` in 1, `s1_tready` out 1: source 1 stream.
- `m_tdata` out 8, `m_tvalid` out 1, `m_tlast` out 1, `m_tready` in 1: output to the TX MAC.
- `m_tuser` out 1: error flag, qualified by `m_tvalid & m_tlast`.
- `grant` out 2: one-hot current owner; 00 when no source owns the path.
- `abort_count` out 8: saturating count of aborted or truncated frames.

## Operation
- **States:** IDLE, XFER, ABORT, FLUSH, GAP.
- **IDLE:**
  - If `enable_arb` is high and any `sN_tvalid` is high, register `grant` and go to XFER next cycle.
  - Clear the byte counter and the stall counter.
- **Arbitration:**
  - Round-robin pointer. The pointer is 0 after reset.
  - If both sources request, the source the pointer selects wins.
  - After any frame ends (normal, abort or truncate), the pointer moves to the source that did not own the path.
- **XFER:**
  - Combinational pass-through of the granted source: `m_tdata`/`m_tvalid`/`m_tlast` equal its signals, and its `sN_tready` = `m_tready`.
  - The non-granted source sees `tready` = 0.
  - A beat is a cycle where `m_tvalid & m_tready` are both high.
- **Normal end:** a beat with the source's `tlast` = 1 ends the frame with `m_tuser` = 0, then go to GAP.
- **Truncate:**
  - On the beat where byte counter = `MAX_FRAME_LEN`-1 and source `tlast` = 0, force `m_tlast` = 1 and `m_tuser` = 1.
  - Increment `abort_count` and go to FLUSH.
  - If that beat already carries `tlast`, it is a normal end.
- **Stall:**
  - The stall counter increments each XFER cycle with granted `tvalid` = 0 and clears on `tvalid` = 1.
  - When it reaches `STALL_TIMEOUT`, go to ABORT.
- **ABORT:**
  - Drive `m_tvalid` = 1, `m_tlast` = 1, `m_tuser` = 1, `m_tdata` = 0, and hold until `m_tready`.
  - Then increment `abort_count` and go to FLUSH.
- **FLUSH:**
  - Granted `sN_tready` = 1 and `m_tvalid` = 0.
  - Discard bytes until a source beat with `tlast` = 1, then go to GAP.
- **GAP:** count `IFG_CYCLES` cycles with `grant` = 00, then go to IDLE.
- **`enable_arb` deasserted mid-frame:** the current frame completes (including FLUSH and GAP). No new grant is issued.
- `abort_count` saturates at 255.

## Timing
- **Reset values:**
  - State IDLE, `grant` = 00.
  - All `sN_tready` = 0.
  - `m_tvalid`, `m_tlast`, `m_tuser` = 0; `m_tdata` = 0.
  - `abort_count` = 0; pointer = 0.
- **Grant latency:** a request seen in IDLE at cycle N gives `grant` and the first possible output beat at N+1. Data latency in XFER is 0 cycles (combinational).
- **Back-to-back frames:** last beat at N, GAP cycles N+1..N+`IFG_CYCLES`, IDLE at N+`IFG_CYCLES`+1, next grant at N+`IFG_CYCLES`+2.
- **Output handshake:** `m_tvalid` is never deasserted in ABORT without `m_tready`. `m_tdata` is stable while `m_tvalid` is high and `m_tready` is low, provided the source obeys AXI-Stream.
- **Byte counter:** 16 bits, increments per beat and never wraps within a frame because truncation occurs first.
- **Reset mid-frame:** all outputs return to reset values asynchronously; the partial frame is not terminated.

## Configuration
- Macro `TX_ARB_FIXED_PRIORITY_EN`.
- **Defined:** source 0 always wins simultaneous requests and the round-robin pointer is removed.
- **Undefined:** round-robin as described.
- All other behaviour is identical.

## Test plan
- **Simultaneous requests:** s0 and s1 each present a 64-byte frame, both valid at cycle 0 → s0 frame first (64 beats, `m_tuser` = 0), 12 gap cycles, then the s1 frame. With the macro defined and s0 re-requesting, s0 wins again.
- **Backpressure:** single s1 frame of 100 bytes, `m_tready` toggling 50% → exactly 100 beats, data in order, `m_tlast` only on byte 100.
- **Truncation:** s0 frame of 1600 bytes, `MAX_FRAME_LEN` = 1514 → beat 1514 has `m_tlast` = 1, `m_tuser` = 1; remaining 86 bytes are flushed with `m_tvalid` = 0; `abort_count` = 1.
- **Stall abort:** s1 sends 10 bytes, then `tvalid` = 0 for 1024 cycles → abort beat with `m_tdata` = 0x00, `m_tlast` = 1, `m_tuser` = 1; flush until s1 `tlast`; `abort_count` increments.
- **Disable mid-frame:** `enable_arb` drops during byte 20 of a 40-byte frame → frame completes, then `grant` stays 00 while both sources hold `tvalid`.
- **Async reset:** assert `axi_tresetn` = 0 during XFER → `grant` = 00 and `m_tvalid` = 0 immediately, without a clock edge.
